fft_butterfly_scheduler: RTL

FFT_BUTTERFLY_SCHEDULER -- requirements
Module: fft_butterfly_scheduler

---
 rtl/fft_butterfly_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fft_butterfly_scheduler.sv
// ---------------------------------------------------------------------------
// fft_butterfly_scheduler
//
// Address and control sequencer for an in-place radix-2 DIT FFT running over
// a single sample RAM with a one-cycle synchronous read. Each pass walks
// log2(N) stages. Each stage issues N/2 butterflies, then spends one DRAIN
// cycle. The DRAIN cycle lets the last write of a stage land before the
// next stage reads. The input data is expected to be in bit-reversed order
// already.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   start          begin one FFT pass (only honoured in IDLE)
//   enable         issue permit; low stalls butterfly issue
//   busy           high whenever the sequencer is not IDLE
//   done           one-cycle pulse at end of pass
//   rd_en          read strobe for the butterfly operands
//   rd_addr_even   even (top) operand address
//   rd_addr_odd    odd (bottom) operand address
//   twiddle_idx    twiddle ROM index for the butterfly being issued
//   wr_en          write strobe for butterfly results (rd_en delayed 1)
//   wr_addr_even   sum destination (rd_addr_even delayed 1)
//   wr_addr_odd    diff destination (rd_addr_odd delayed 1)
//   stage_idx      current stage, 0..log2(N)-1
// ---------------------------------------------------------------------------
module fft_butterfly_scheduler #(
    parameter  int FFT_POINTS  = 8,
    localparam int ADDR_WIDTH  = $clog2(FFT_POINTS),
    localparam int TW_WIDTH    = ADDR_WIDTH - 1,
    localparam int STAGE_WIDTH = $clog2(ADDR_WIDTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   enable,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr_even,
    output logic [ADDR_WIDTH-1:0]  rd_addr_odd,
    output logic [TW_WIDTH-1:0]    twiddle_idx,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr_even,
    output logic [ADDR_WIDTH-1:0]  wr_addr_odd,
    output logic [STAGE_WIDTH-1:0] stage_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [TW_WIDTH-1:0]    LAST_J     = TW_WIDTH'(FFT_POINTS / 2 - 1);
    localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(ADDR_WIDTH - 1);

    state_t                 state_reg, state_next;
    logic [TW_WIDTH-1:0]    j_reg, j_next;
    logic [STAGE_WIDTH-1:0] stage_reg, stage_next;

    logic                   wr_en_reg;
    logic [ADDR_WIDTH-1:0]  wr_addr_even_reg, wr_addr_odd_reg;

    logic [TW_WIDTH-1:0]    pos_mask;
    logic [TW_WIDTH-1:0]    pos;
    logic [ADDR_WIDTH-1:0]  j_ext;
    logic [ADDR_WIDTH-1:0]  half;
    logic [ADDR_WIDTH-1:0]  even_addr;
    logic [STAGE_WIDTH-1:0] tw_shift;
    logic                   issuing;

    // pos_mask = half-1: the low 'stage' bits of j select the position
    // inside a group, the remaining bits select the group.
    genvar gi;
    generate
        for (gi = 0; gi < TW_WIDTH; gi++) begin : g_pos_mask
            assign pos_mask[gi] = (STAGE_WIDTH'(gi) < stage_reg);
        end
    endgenerate

    assign pos   = j_reg & pos_mask;
    assign j_ext = {1'b0, j_reg};
    assign half  = ADDR_WIDTH'(1) << stage_reg;

    // group*2*half + pos: clearing the position bits of j and shifting the
    // group field up by one leaves bit 'stage' free for the odd operand.
    assign even_addr = ((j_ext & ~{1'b0, pos_mask}) << 1) | {1'b0, pos};
    assign tw_shift  = STAGE_WIDTH'(TW_WIDTH) - stage_reg;

    assign issuing = (state_reg == ISSUE);

    // Addresses are forced to zero outside ISSUE so that reset (and idle)
    // presents all-zero addresses rather than the j=0 pattern (0,1).
    assign rd_en        = issuing & enable;
    assign rd_addr_even = issuing ? even_addr : '0;
    assign rd_addr_odd  = issuing ? (even_addr | half) : '0;
    assign twiddle_idx  = issuing ? TW_WIDTH'(pos << tw_shift) : '0;

    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign stage_idx    = stage_reg;
    assign wr_en        = wr_en_reg;
    assign wr_addr_even = wr_addr_even_reg;
    assign wr_addr_odd  = wr_addr_odd_reg;

    always_comb begin
        state_next = state_reg;
        j_next     = j_reg;
        stage_next = stage_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                    j_next     = '0;
                    stage_next = '0;
                end
            end
            ISSUE: begin
                if (enable) begin
                    if (j_reg == LAST_J) begin
                        state_next = DRAIN;
                        j_next     = '0;
                    end else begin
                        j_next = j_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (stage_reg == LAST_STAGE) begin
                    state_next = DONE;
                end else begin
                    state_next = ISSUE;
                    stage_next = stage_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                stage_next = '0;
            end
            default: begin
                state_next = IDLE;
                j_next     = '0;
                stage_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            j_reg            <= '0;
            stage_reg        <= '0;
            wr_en_reg        <= 1'b0;
            wr_addr_even_reg <= '0;
            wr_addr_odd_reg  <= '0;
        end else begin
            state_reg        <= state_next;
            j_reg            <= j_next;
            stage_reg        <= stage_next;
            // Write-back trails the read by the RAM latency regardless of
            // state, so butterflies issued late in a stage still retire.
            wr_en_reg        <= rd_en;
            wr_addr_even_reg <= rd_addr_even;
            wr_addr_odd_reg  <= rd_addr_odd;
        end
    end

endmodule
